// File: rtl/uart_rx_fsm.sv
// uart_rx_fsm -- receive-side sequencer for the UART RX path.
//
// Detects the start bit, counts oversampling edges within each bit and bit
// positions within the frame, strobes the external deserializer once per
// data bit, and checks the start, parity and stop bits. A clean frame ends
// with a one-cycle data_valid pulse; a bad one ends with exactly one of
// strt_glitch, par_err or stp_err instead.
//
// Ports
//   CLK          receive oversampling clock
//   RST          asynchronous, active-low reset
//   RX_IN        serial line, idle high, already synchronized
//   Prescale     oversampling ratio (8, 16 or 32), latched at frame start
//   PAR_EN       1 = frame carries a parity bit, latched at frame start
//   PAR_TYP      0 = even, 1 = odd, latched at frame start
//   sampled_bit  data-sampler majority result, valid on bit-end cycles
//   dat_samp_en  data-sampler enable, high whenever not IDLE
//   edge_cnt     oversampling edge index within the current bit
//   deser_en     deserializer shift strobe (DATA bit-end cycles only)
//   data_valid   one-cycle pulse, good frame complete
//   par_err      one-cycle pulse, parity mismatch
//   stp_err      one-cycle pulse, stop bit sampled 0
//   strt_glitch  one-cycle pulse, start bit sampled 1
//
// state  | meaning
// IDLE   | line idle, waiting for RX_IN low
// START  | inside the start bit
// DATA   | inside one of the 8 data bits
// PARITY | inside the parity bit
// STOP   | inside the stop bit

module uart_rx_fsm (
  input  logic       CLK,
  input  logic       RST,
  input  logic       RX_IN,
  input  logic [5:0] Prescale,
  input  logic       PAR_EN,
  input  logic       PAR_TYP,
  input  logic       sampled_bit,
  output logic       dat_samp_en,
  output logic [5:0] edge_cnt,
  output logic       deser_en,
  output logic       data_valid,
  output logic       par_err,
  output logic       stp_err,
  output logic       strt_glitch
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  state_t     state_q,       state_d;
  logic [5:0] edge_cnt_q,    edge_cnt_d;
  logic [5:0] prescale_q,    prescale_d;
  logic       par_en_q,      par_en_d;
  logic       par_typ_q,     par_typ_d;
  logic [2:0] bit_cnt_q,     bit_cnt_d;
  logic       acc_q,         acc_d;
  logic       par_fail_q,    par_fail_d;
  logic       data_valid_q,  data_valid_d;
  logic       par_err_q,     par_err_d;
  logic       stp_err_q,     stp_err_d;
  logic       strt_glitch_q, strt_glitch_d;

  logic       bit_end;

  assign bit_end = (state_q != S_IDLE) && (edge_cnt_q == (prescale_q - 6'd1));

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q       <= S_IDLE;
      edge_cnt_q    <= '0;
      prescale_q    <= '0;
      par_en_q      <= 1'b0;
      par_typ_q     <= 1'b0;
      bit_cnt_q     <= '0;
      acc_q         <= 1'b0;
      par_fail_q    <= 1'b0;
      data_valid_q  <= 1'b0;
      par_err_q     <= 1'b0;
      stp_err_q     <= 1'b0;
      strt_glitch_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      edge_cnt_q    <= edge_cnt_d;
      prescale_q    <= prescale_d;
      par_en_q      <= par_en_d;
      par_typ_q     <= par_typ_d;
      bit_cnt_q     <= bit_cnt_d;
      acc_q         <= acc_d;
      par_fail_q    <= par_fail_d;
      data_valid_q  <= data_valid_d;
      par_err_q     <= par_err_d;
      stp_err_q     <= stp_err_d;
      strt_glitch_q <= strt_glitch_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    prescale_d    = prescale_q;
    par_en_d      = par_en_q;
    par_typ_d     = par_typ_q;
    bit_cnt_d     = bit_cnt_q;
    acc_d         = acc_q;
    par_fail_d    = par_fail_q;
    data_valid_d  = 1'b0;
    par_err_d     = 1'b0;
    stp_err_d     = 1'b0;
    strt_glitch_d = 1'b0;

    // Edge counter runs only inside a frame and restarts at every bit-end.
    if (state_q == S_IDLE || bit_end) begin
      edge_cnt_d = '0;
    end else begin
      edge_cnt_d = edge_cnt_q + 6'd1;
    end

    case (state_q)
      S_IDLE: begin
        if (!RX_IN) begin
          state_d    = S_START;
          prescale_d = Prescale;
          par_en_d   = PAR_EN;
          par_typ_d  = PAR_TYP;
          bit_cnt_d  = '0;
          acc_d      = 1'b0;
        end
      end

      S_START: begin
        if (bit_end) begin
          if (sampled_bit) begin
            strt_glitch_d = 1'b1;
            state_d       = S_IDLE;
          end else begin
            state_d = S_DATA;
          end
        end
      end

      S_DATA: begin
        if (bit_end) begin
          acc_d     = acc_q ^ sampled_bit;
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) begin
            state_d = par_en_q ? S_PARITY : S_STOP;
          end
        end
      end

      S_PARITY: begin
        if (bit_end) begin
          if (sampled_bit != (acc_q ^ par_typ_q)) begin
            par_fail_d = 1'b1;
          end
          state_d = S_STOP;
        end
      end

      S_STOP: begin
        if (bit_end) begin
          state_d    = S_IDLE;
          par_fail_d = 1'b0;
          // A bad stop bit outranks a parity failure.
          if (!sampled_bit) begin
            stp_err_d = 1'b1;
          end else if (par_fail_q) begin
            par_err_d = 1'b1;
          end else begin
            data_valid_d = 1'b1;
          end
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Combinational so the deserializer captures sampled_bit on this same edge.
  assign deser_en    = (state_q == S_DATA) && bit_end;
  assign dat_samp_en = (state_q != S_IDLE);
  assign edge_cnt    = edge_cnt_q;
  assign data_valid  = data_valid_q;
  assign par_err     = par_err_q;
  assign stp_err     = stp_err_q;
  assign strt_glitch = strt_glitch_q;

endmodule

// File: tb/tb_uart_rx_fsm.sv
// Directed bench for uart_rx_fsm. Stimulus is laid out per cycle in rx_v /
// sb_v (cycle 0 = first cycle RX_IN is low in IDLE); a small bench-side
// shift register plays the deserializer on each deser_en strobe.

module tb_uart_rx_fsm;

  logic       CLK = 1'b0;
  logic       RST;
  logic       RX_IN;
  logic [5:0] Prescale;
  logic       PAR_EN;
  logic       PAR_TYP;
  logic       sampled_bit;
  logic       dat_samp_en;
  logic [5:0] edge_cnt;
  logic       deser_en;
  logic       data_valid;
  logic       par_err;
  logic       stp_err;
  logic       strt_glitch;

  uart_rx_fsm dut (
    .CLK         (CLK),
    .RST         (RST),
    .RX_IN       (RX_IN),
    .Prescale    (Prescale),
    .PAR_EN      (PAR_EN),
    .PAR_TYP     (PAR_TYP),
    .sampled_bit (sampled_bit),
    .dat_samp_en (dat_samp_en),
    .edge_cnt    (edge_cnt),
    .deser_en    (deser_en),
    .data_valid  (data_valid),
    .par_err     (par_err),
    .stp_err     (stp_err),
    .strt_glitch (strt_glitch)
  );

  always #5 CLK = ~CLK;

  localparam int NCYC = 700;

  int         total = 0;
  int         bad   = 0;
  logic       rx_v [0:NCYC-1];
  logic       sb_v [0:NCYC-1];
  logic       ds_v [0:NCYC-1];
  logic [5:0] ec_v [0:NCYC-1];
  int         de_q[$];
  int         dv_q[$];
  int         pe_q[$];
  int         se_q[$];
  int         sg_q[$];
  int         pd_q[$];
  logic [7:0] pdata = 8'h00;
  int         flip_cyc = -1;

  task automatic chk(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int qat(input int q[$], input int i);
    return (i < q.size()) ? q[i] : -1;
  endfunction

  function automatic void clear_stim();
    for (int i = 0; i < NCYC; i++) begin
      rx_v[i] = 1'b1;
      sb_v[i] = 1'b1;
    end
  endfunction

  // Frame bits, index 0 = start bit, data LSB first.
  function automatic logic [10:0] fbits(input logic [7:0] d, input logic pe,
                                        input logic pb, input logic st);
    return pe ? {st, pb, d, 1'b0} : {1'b1, st, d, 1'b0};
  endfunction

  // Line shows bit k over cycles s+kP .. s+kP+P-1; the sampler reports bit k
  // one cycle later so that bit k's value is present on its bit-end cycle.
  function automatic void add_frame(input int s, input logic [10:0] b,
                                    input int nb, input int p);
    for (int c = 0; c < nb * p; c++) rx_v[s + c] = b[c / p];
    for (int c = 1; c <= nb * p; c++) sb_v[s + c] = b[(c - 1) / p];
  endfunction

  task automatic run(input int ncyc);
    de_q.delete(); dv_q.delete(); pe_q.delete();
    se_q.delete(); sg_q.delete(); pd_q.delete();
    for (int c = 0; c < ncyc; c++) begin
      @(negedge CLK);
      ds_v[c] = dat_samp_en;
      ec_v[c] = edge_cnt;
      if (deser_en) begin
        de_q.push_back(c);
        pdata = {sb_v[c], pdata[7:1]};
      end
      if (data_valid) begin
        dv_q.push_back(c);
        pd_q.push_back(int'(pdata));
      end
      if (par_err)     pe_q.push_back(c);
      if (stp_err)     se_q.push_back(c);
      if (strt_glitch) sg_q.push_back(c);
      if (c == flip_cyc) begin
        PAR_TYP  = ~PAR_TYP;
        PAR_EN   = ~PAR_EN;
        Prescale = 6'd8;
      end
      RX_IN       = rx_v[c];
      sampled_bit = sb_v[c];
    end
  endtask

  logic typ_t [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
  logic pb_t  [4] = '{1'b0, 1'b1, 1'b1, 1'b0};
  int   dv_t  [4] = '{1, 0, 1, 0};

  initial begin
    RST = 1'b0; RX_IN = 1'b1; sampled_bit = 1'b1;
    Prescale = 6'd8; PAR_EN = 1'b0; PAR_TYP = 1'b0;
    #2;
    chk("rst_dat_samp_en", int'(dat_samp_en), 0);
    chk("rst_edge_cnt",    int'(edge_cnt),    0);
    chk("rst_deser_en",    int'(deser_en),    0);
    chk("rst_data_valid",  int'(data_valid),  0);
    chk("rst_par_err",     int'(par_err),     0);
    chk("rst_stp_err",     int'(stp_err),     0);
    chk("rst_strt_glitch", int'(strt_glitch), 0);
    repeat (2) @(negedge CLK);
    RST = 1'b1;

    // Clean frame, no parity, P=8, 0xA5.
    Prescale = 6'd8; PAR_EN = 1'b0; PAR_TYP = 1'b0;
    clear_stim();
    add_frame(0, fbits(8'hA5, 1'b0, 1'b0, 1'b1), 10, 8);
    run(90);
    chk("t1_deser_count", de_q.size(), 8);
    for (int j = 0; j < 8; j++) chk("t1_deser_cyc", qat(de_q, j), 16 + 8 * j);
    chk("t1_dv_count", dv_q.size(), 1);
    chk("t1_dv_cyc",   qat(dv_q, 0), 81);
    chk("t1_pdata",    qat(pd_q, 0), 'hA5);
    chk("t1_err_count", pe_q.size() + se_q.size() + sg_q.size(), 0);
    chk("t1_edge_cnt_bitend", int'(ec_v[80]), 7);
    chk("t1_edge_cnt_idle",   int'(ec_v[81]), 0);
    chk("t1_samp_en_stop",    int'(ds_v[80]), 1);
    chk("t1_samp_en_idle",    int'(ds_v[81]), 0);

    // Parity frames, P=16, 0x3C (four ones). Third case also changes the
    // config inputs mid-frame, which must have no effect.
    for (int k = 0; k < 4; k++) begin
      Prescale = 6'd16; PAR_EN = 1'b1; PAR_TYP = typ_t[k];
      clear_stim();
      add_frame(0, fbits(8'h3C, 1'b1, pb_t[k], 1'b1), 11, 16);
      flip_cyc = (k == 2) ? 50 : -1;
      run(185);
      flip_cyc = -1;
      chk("t2_dv_count", dv_q.size(), dv_t[k]);
      chk("t2_pe_count", pe_q.size(), 1 - dv_t[k]);
      chk("t2_event_cyc", (dv_t[k] == 1) ? qat(dv_q, 0) : qat(pe_q, 0), 177);
      chk("t2_deser_count", de_q.size(), 8);
      chk("t2_pdata", int'(pdata), 'h3C);
    end

    // Start glitch, P=8: line low two cycles only.
    Prescale = 6'd8; PAR_EN = 1'b0; PAR_TYP = 1'b0;
    clear_stim();
    rx_v[0] = 1'b0;
    rx_v[1] = 1'b0;
    run(20);
    chk("t3_sg_count", sg_q.size(), 1);
    chk("t3_sg_cyc",   qat(sg_q, 0), 9);
    chk("t3_deser_count", de_q.size(), 0);
    chk("t3_other_count", dv_q.size() + pe_q.size() + se_q.size(), 0);
    chk("t3_samp_en_start", int'(ds_v[8]), 1);
    chk("t3_samp_en_idle",  int'(ds_v[9]), 0);
    chk("t3_edge_cnt_end",  int'(ec_v[8]), 7);

    // Stop error at P=32 with the line held low, then a good frame starting
    // in the stp_err cycle itself.
    Prescale = 6'd32; PAR_EN = 1'b0; PAR_TYP = 1'b0;
    clear_stim();
    add_frame(0, fbits(8'h96, 1'b0, 1'b0, 1'b0), 10, 32);
    rx_v[320] = 1'b0;
    add_frame(321, fbits(8'h4B, 1'b0, 1'b0, 1'b1), 10, 32);
    run(660);
    chk("t4_se_count", se_q.size(), 1);
    chk("t4_se_cyc",   qat(se_q, 0), 321);
    chk("t4_dv_count", dv_q.size(), 1);
    chk("t4_dv_cyc",   qat(dv_q, 0), 642);
    chk("t4_pdata",    qat(pd_q, 0), 'h4B);
    chk("t4_deser_count", de_q.size(), 16);
    chk("t4_pe_sg_count", pe_q.size() + sg_q.size(), 0);

    // Back-to-back frames at P=8; the second start is seen in the first
    // frame's data_valid cycle, so pulses are N*P+1 cycles apart.
    Prescale = 6'd8; PAR_EN = 1'b0; PAR_TYP = 1'b0;
    clear_stim();
    add_frame(0,  fbits(8'h01, 1'b0, 1'b0, 1'b1), 10, 8);
    add_frame(81, fbits(8'hFE, 1'b0, 1'b0, 1'b1), 10, 8);
    run(170);
    chk("t5_dv_count", dv_q.size(), 2);
    chk("t5_dv0_cyc",  qat(dv_q, 0), 81);
    chk("t5_dv1_cyc",  qat(dv_q, 1), 162);
    chk("t5_pdata0",   qat(pd_q, 0), 'h01);
    chk("t5_pdata1",   qat(pd_q, 1), 'hFE);
    chk("t5_deser_count", de_q.size(), 16);

    // Reset during data bit 4, then a fresh 0x55 frame.
    clear_stim();
    add_frame(0, fbits(8'hA5, 1'b0, 1'b0, 1'b1), 10, 8);
    run(44);
    chk("t6_midframe_samp_en", int'(ds_v[43]), 1);
    chk("t6_midframe_edge",    int'(ec_v[43]), 2);
    #2;
    RST = 1'b0;
    #1;
    chk("t6_rst_dat_samp_en", int'(dat_samp_en), 0);
    chk("t6_rst_edge_cnt",    int'(edge_cnt),    0);
    chk("t6_rst_deser_en",    int'(deser_en),    0);
    chk("t6_rst_flags", int'(data_valid) + int'(par_err) + int'(stp_err) + int'(strt_glitch), 0);
    RX_IN = 1'b1; sampled_bit = 1'b1;
    repeat (3) @(negedge CLK);
    RST = 1'b1;
    clear_stim();
    add_frame(0, fbits(8'h55, 1'b0, 1'b0, 1'b1), 10, 8);
    run(90);
    chk("t6_dv_count", dv_q.size(), 1);
    chk("t6_dv_cyc",   qat(dv_q, 0), 81);
    chk("t6_pdata",    qat(pd_q, 0), 'h55);
    chk("t6_deser_count", de_q.size(), 8);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
